// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
//
// Keypad-driven sequencer for the two-function (add/sub) calculator datapath.
// It sits between the keypad scanner and the arithmetic unit. It builds
// decimal operands from digit keys and issues one-cycle load strobes for
// A, B and the result latch. It selects what the output unit displays and
// allows chaining a new operation onto the previous result.
//
// Key events are qualified on the rising edge of trig. The captured key is
// acted on one clock later, so '=' to disp_sel=1 takes three clocks:
// ld_b, then ld_r, then disp_sel.
//
// Parameters:
//   WIDTH       operand/result width in bits
//   MAX_DIGITS  decimal digits accepted per entry; extra digits are ignored
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset (0 = reset)
//   trig         key-valid level from the scanner, one rising edge per press
//   key_value    key code: 0-9 digit, 0xA '+', 0xB '-', 0xC '=', 0xD-0xF none
//   clear_entry  clear the current entry (level)
//   clear_all    clear everything and pulse au_clear (level)
//   result       arithmetic-unit result, used when chaining
//   operand      value driven to the arithmetic-unit X input
//   ld_a         one-cycle load-A strobe
//   ld_b         one-cycle load-B strobe
//   add_sub      0 = add, 1 = subtract, held between operator keys
//   ld_r         one-cycle result-latch strobe
//   au_clear     one-cycle arithmetic-unit clear
//   disp_sel     0 = display entry, 1 = display result
//   err          sticky entry-overflow flag
//   state        current FSM state (debug)
//
// Optional feature macro: CALC_OVF_CHECK_EN
//   defined   : a digit that would push the entry past 2^WIDTH-1 is rejected,
//               and err is set until clear_entry, clear_all or reset
//   undefined : the entry wraps modulo 2^WIDTH and err stays 0
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [3:0]       key_value,
  input  logic             clear_entry,
  input  logic             clear_all,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] operand,
  output logic             ld_a,
  output logic             ld_b,
  output logic             add_sub,
  output logic             ld_r,
  output logic             au_clear,
  output logic             disp_sel,
  output logic             err,
  output logic [2:0]       state
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER_A = 3'd1,
    LOAD_A  = 3'd2,
    ENTER_B = 3'd3,
    LOAD_B  = 3'd4,
    EXEC    = 3'd5,
    SHOW    = 3'd6
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic             trig_q;
  logic             key_pend;
  logic             key_pend_n;
  logic [3:0]       key_code;
  logic [3:0]       key_code_n;
  logic [WIDTH-1:0] entry;
  logic [WIDTH-1:0] entry_n;
  logic [WIDTH-1:0] operand_n;
  logic [CNT_W-1:0] digit_cnt;
  logic [CNT_W-1:0] digit_cnt_n;
  logic             ld_a_n;
  logic             ld_b_n;
  logic             ld_r_n;
  logic             au_clear_n;
  logic             add_sub_n;
  logic             disp_sel_n;
  logic             err_n;
  logic             key_edge;
  logic             busy;
  logic             is_digit;
  logic             is_op;
  logic             is_eq;
  logic             digit_room;
  logic             digit_fits;
  logic [WIDTH-1:0] digit_val;

  // Key qualification: a press is the first cycle trig is seen high.
  // Presses landing in the transient load/execute states are dropped, and
  // any clear in the same cycle outranks the press.
  assign key_edge   = trig & ~trig_q;
  assign busy       = (cur_state == LOAD_A) || (cur_state == LOAD_B) ||
                      (cur_state == EXEC);
  assign is_digit   = (key_code <= 4'd9);
  assign is_op      = (key_code == 4'hA) || (key_code == 4'hB);
  assign is_eq      = (key_code == 4'hC);
  assign digit_room = (digit_cnt < CNT_W'(MAX_DIGITS));

  // Next entry value for a digit key, entry*10 + d built from shifts.
  // With overflow checking the sum is kept four bits wider so a result that
  // no longer fits in WIDTH bits can be detected and refused.
`ifdef CALC_OVF_CHECK_EN
  logic [WIDTH+3:0] digit_sum;
  assign digit_sum  = ({4'b0000, entry} << 3) + ({4'b0000, entry} << 1) +
                      {{WIDTH{1'b0}}, key_code};
  assign digit_fits = (digit_sum[WIDTH+3:WIDTH] == 4'b0000);
  assign digit_val  = digit_sum[WIDTH-1:0];
`else
  logic [WIDTH-1:0] digit_sum;
  assign digit_sum  = (entry << 3) + (entry << 1) + WIDTH'(key_code);
  assign digit_fits = 1'b1;
  assign digit_val  = digit_sum;
`endif

  // State and output registers. Every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= IDLE;
      trig_q    <= 1'b0;
      key_pend  <= 1'b0;
      key_code  <= 4'd0;
      entry     <= '0;
      digit_cnt <= '0;
      operand   <= '0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      ld_r      <= 1'b0;
      au_clear  <= 1'b0;
      add_sub   <= 1'b0;
      disp_sel  <= 1'b0;
      err       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      trig_q    <= trig;
      key_pend  <= key_pend_n;
      key_code  <= key_code_n;
      entry     <= entry_n;
      digit_cnt <= digit_cnt_n;
      operand   <= operand_n;
      ld_a      <= ld_a_n;
      ld_b      <= ld_b_n;
      ld_r      <= ld_r_n;
      au_clear  <= au_clear_n;
      add_sub   <= add_sub_n;
      disp_sel  <= disp_sel_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output logic. Strobes default low so each is a
  // single-cycle pulse. operand tracks entry one cycle behind, except in the
  // load/execute states where it holds the value being loaded. A clear_all
  // overrides everything, which also cancels any strobe due that cycle.
  // A clear_entry acts only in the entry states and SHOW, so a
  // load/execute sequence that has started always completes.
  always_comb begin
    nxt_state   = cur_state;
    key_pend_n  = key_edge & ~busy & ~clear_all & ~clear_entry;
    key_code_n  = key_edge ? key_value : key_code;
    entry_n     = entry;
    digit_cnt_n = digit_cnt;
    operand_n   = entry;
    ld_a_n      = 1'b0;
    ld_b_n      = 1'b0;
    ld_r_n      = 1'b0;
    au_clear_n  = 1'b0;
    add_sub_n   = add_sub;
    disp_sel_n  = disp_sel;
    err_n       = err;

    if (clear_all) begin
      nxt_state   = IDLE;
      entry_n     = '0;
      digit_cnt_n = '0;
      operand_n   = '0;
      err_n       = 1'b0;
      disp_sel_n  = 1'b0;
      add_sub_n   = 1'b0;
      au_clear_n  = 1'b1;
    end else if (clear_entry && (cur_state == IDLE || cur_state == ENTER_A ||
                                 cur_state == ENTER_B)) begin
      entry_n     = '0;
      digit_cnt_n = '0;
      err_n       = 1'b0;
    end else if (clear_entry && cur_state == SHOW) begin
      nxt_state   = IDLE;
      entry_n     = '0;
      digit_cnt_n = '0;
      disp_sel_n  = 1'b0;
    end else begin
      case (cur_state)
        IDLE, ENTER_A: begin
          if (key_pend && is_digit) begin
            nxt_state = ENTER_A;
            if (digit_room) begin
              if (digit_fits) begin
                entry_n     = digit_val;
                digit_cnt_n = digit_cnt + CNT_W'(1);
              end else begin
                err_n = 1'b1;
              end
            end
          end else if (key_pend && is_op) begin
            add_sub_n = key_code[0];
            ld_a_n    = 1'b1;
            nxt_state = LOAD_A;
          end
        end
        LOAD_A: begin
          operand_n   = operand;
          entry_n     = '0;
          digit_cnt_n = '0;
          nxt_state   = ENTER_B;
        end
        ENTER_B: begin
          if (key_pend && is_digit) begin
            if (digit_room) begin
              if (digit_fits) begin
                entry_n     = digit_val;
                digit_cnt_n = digit_cnt + CNT_W'(1);
              end else begin
                err_n = 1'b1;
              end
            end
          end else if (key_pend && is_op) begin
            add_sub_n = key_code[0];
          end else if (key_pend && is_eq) begin
            ld_b_n    = 1'b1;
            nxt_state = LOAD_B;
          end
        end
        LOAD_B: begin
          operand_n = operand;
          ld_r_n    = 1'b1;
          nxt_state = EXEC;
        end
        EXEC: begin
          operand_n  = operand;
          disp_sel_n = 1'b1;
          nxt_state  = SHOW;
        end
        SHOW: begin
          if (key_pend && is_op) begin
            operand_n  = result;
            add_sub_n  = key_code[0];
            ld_a_n     = 1'b1;
            disp_sel_n = 1'b0;
            nxt_state  = LOAD_A;
          end else if (key_pend && is_digit) begin
            entry_n     = WIDTH'(key_code);
            digit_cnt_n = CNT_W'(1);
            disp_sel_n  = 1'b0;
            nxt_state   = ENTER_A;
          end
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end

`ifndef CALC_OVF_CHECK_EN
    err_n = 1'b0;
`endif
  end

  assign state = cur_state;

endmodule
